// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core fetch/load-store ports, the arbiter and the
// unified single-port memory. The arbiter connects through the slave modport;
// the environment (core + memory) drives through the master modport.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction-fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    // Load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    // Memory side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    // Status
    logic          stall;
    logic          timeout_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, timeout_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch port and the load/store port. One transaction at a time:
// IDLE (grant) -> BUSY_I/BUSY_D (mem_req held) -> RESP (one-cycle ready pulse).
// A watchdog aborts a BUSY phase after TIMEOUT_CYC cycles without mem_ready
// (TIMEOUT_CYC = 0 disables it) and sets the sticky timeout_err flag.
// Build option: define ARB_RR_EN for round-robin on simultaneous requests;
// without it the data port always wins.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // The counter only ever needs to reach TIMEOUT_CYC-1: the abort fires on
    // the cycle that would have made it TIMEOUT_CYC.
    localparam int             WDW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
    localparam bit             WD_EN   = (TIMEOUT_CYC != 0);

    logic [1:0]     r_state;
    logic           r_mem_req;
    logic           r_mem_we;
    logic [AW-1:0]  r_mem_addr;
    logic [DW-1:0]  r_mem_wdata;
    logic [DW-1:0]  r_if_rdata;
    logic [DW-1:0]  r_d_rdata;
    logic           r_if_ready;
    logic           r_d_ready;
    logic           r_timeout_err;
    logic [WDW-1:0] r_wdog;

    logic           w_any_req;
    logic           w_grant_d;
    logic           w_wd_expire;

    assign w_any_req = bus.if_req | bus.d_req;

`ifdef ARB_RR_EN
    // Port served by the most recent grant: 0 = fetch, 1 = data.
    logic r_last_d;

    // On contention serve the port that did not win last time; a lone request wins outright.
    always_comb begin
        w_grant_d = bus.d_req;
        if (bus.if_req && bus.d_req) begin
            w_grant_d = ~r_last_d;
        end
    end

    // Remember who won each grant so the next contention alternates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    // Fixed priority: a pending load/store is the older instruction and always wins.
    assign w_grant_d = bus.d_req;
`endif

    // Abort when this BUSY cycle would be the TIMEOUT_CYC-th without mem_ready.
    assign w_wd_expire = WD_EN && (r_wdog == WD_LAST) && !bus.mem_ready;

    // Transaction sequencer: grant, wait for memory or watchdog, pulse the ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_rdata    <= '0;
            r_d_rdata     <= '0;
            r_if_ready    <= 1'b0;
            r_d_ready     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_mem_req <= 1'b1;
                        r_wdog    <= '0;
                        if (w_grant_d) begin
                            r_mem_we    <= bus.d_we;
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            r_state     <= S_BUSY_D;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= bus.if_addr;
                            r_state     <= S_BUSY_I;
                        end
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (bus.mem_ready) begin
                        // Stores never touch d_rdata; it keeps the last load value.
                        if (r_state == S_BUSY_I) begin
                            r_if_rdata <= bus.mem_rdata;
                        end else if (!r_mem_we) begin
                            r_d_rdata  <= bus.mem_rdata;
                        end
                        r_mem_req  <= 1'b0;
                        r_if_ready <= (r_state == S_BUSY_I);
                        r_d_ready  <= (r_state == S_BUSY_D);
                        r_state    <= S_RESP;
                    end else if (w_wd_expire) begin
                        // Still complete the handshake so the core cannot deadlock.
                        r_mem_req     <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_if_ready    <= (r_state == S_BUSY_I);
                        r_d_ready     <= (r_state == S_BUSY_D);
                        r_state       <= S_RESP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    // Requesters update req on the edge ending the pulse, so IDLE
                    // never sees the request just completed.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.if_ready    = r_if_ready;
    assign bus.d_ready     = r_d_ready;
    assign bus.timeout_err = r_timeout_err;
    assign bus.stall       = (bus.if_req & ~r_if_ready) | (bus.d_req & ~r_d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for contention, sustained contention, watchdog abort and mid-transaction reset.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          port_d;   // 1 = load/store port, 0 = fetch port
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_rd;   // value the memory returns
        int          lat;      // BUSY cycles before mem_ready
        logic [31:0] exp_rd;   // expected rdata of the port (loads/fetches)
    } vec_t;

    vec_t        tbl [6];
    int          nchk = 0;
    int          nerr = 0;
    int          n;
    int          nif;
    bit          g;
    bit          exp_g [4];
    logic [31:0] prev_d;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] pd;
        pd = bus.d_rdata;
        if (v.port_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        #1;
        check("stall_on_req", 32'(bus.stall), 1);
        step();
        check("mem_req_grant", 32'(bus.mem_req), 1);
        check("mem_addr", bus.mem_addr, v.addr);
        check("mem_we", 32'(bus.mem_we), 32'(v.we));
        if (v.we) check("mem_wdata", bus.mem_wdata, v.wdata);
        check("stall_busy", 32'(bus.stall), 1);
        for (int k = 0; k < v.lat; k++) begin
            step();
            check("mem_req_hold", 32'(bus.mem_req), 1);
            check("no_early_ready", 32'({bus.if_ready, bus.d_ready}), 0);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = v.mem_rd;
        step();
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        check("mem_req_done", 32'(bus.mem_req), 0);
        check("if_ready_pulse", 32'(bus.if_ready), v.port_d ? 0 : 1);
        check("d_ready_pulse", 32'(bus.d_ready), v.port_d ? 1 : 0);
        check("stall_resp", 32'(bus.stall), 0);
        if (!v.port_d) check("if_rdata", bus.if_rdata, v.exp_rd);
        if (v.port_d && !v.we) check("d_rdata_load", bus.d_rdata, v.exp_rd);
        else check("d_rdata_kept", bus.d_rdata, pd);
        step();
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        check("ready_single", 32'({bus.if_ready, bus.d_ready}), 0);
    endtask

    initial begin
        //            port we  addr          wdata         mem_rd        lat exp_rd
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h8C01_0004, 0, 32'h8C01_0004};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0005, 32'h0,        2, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_0005, 1, 32'h0000_0005};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_0030, 32'hAAAA_5555, 32'hFFFF_FFFF, 0, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,        32'h1234_5678, 3, 32'h1234_5678};
`ifdef ARB_RR_EN
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ready = 0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_readies", 32'({bus.if_ready, bus.d_ready}), 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_timeout_err", 32'(bus.timeout_err), 0);
        check("rst_stall", 32'(bus.stall), 0);

        // Contention: store on data port beats the fetch, then the fetch is served
        prev_d = bus.d_rdata;
        bus.if_req = 1; bus.if_addr = 32'h44;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'h7;
        step();
        check("cont1_we", 32'(bus.mem_we), 1);
        check("cont1_addr", bus.mem_addr, 32'h100);
        check("cont1_wdata", bus.mem_wdata, 32'h7);
        bus.mem_ready = 1; step(); bus.mem_ready = 0;
        check("cont1_ready", 32'({bus.if_ready, bus.d_ready}), 32'b01);
        check("cont1_stall_if", 32'(bus.stall), 1);
        check("cont1_d_rdata", bus.d_rdata, prev_d);
        step();
        bus.d_req = 0; bus.d_we = 0;
        step();
        check("cont2_req", 32'(bus.mem_req), 1);
        check("cont2_addr", bus.mem_addr, 32'h44);
        check("cont2_we", 32'(bus.mem_we), 0);
        bus.mem_ready = 1; bus.mem_rdata = 32'hCAFE_0044; step(); bus.mem_ready = 0;
        check("cont2_ready", 32'({bus.if_ready, bus.d_ready}), 32'b10);
        check("cont2_if_rdata", bus.if_rdata, 32'hCAFE_0044);
        check("cont2_d_rdata", bus.d_rdata, prev_d);
        step();
        bus.if_req = 0;
        step();

        // Single transactions from the table (last row is a fetch)
        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Sustained contention: both ports re-request after every ready
        bus.if_req = 1; bus.if_addr = 32'h300;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h400; bus.d_wdata = 32'h1;
        nif = 0;
        for (int r = 0; r < 4; r++) begin
            n = 0;
            while (!bus.mem_req && n < 6) begin step(); n++; end
            check("rr_grant_seen", 32'(bus.mem_req), 1);
            g = bus.mem_we;
            check("rr_grant_port", 32'(g), 32'(exp_g[r]));
            bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_0000 + r; step(); bus.mem_ready = 0;
            if (bus.if_ready) nif++;
            check("rr_ready", 32'({bus.if_ready, bus.d_ready}), g ? 32'b01 : 32'b10);
            step();
            if (g) begin bus.d_addr += 4; bus.d_wdata += 1; end
            else bus.if_addr += 4;
        end
        bus.if_req = 0; bus.d_req = 0; bus.d_we = 0;
`ifdef ARB_RR_EN
        check("rr_if_ready_count", 32'(nif), 2);
`else
        check("rr_if_ready_count", 32'(nif), 0);
`endif
        step();

        // Watchdog: load that never completes
        prev_d = bus.d_rdata;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        step();
        check("wd_err_before", 32'(bus.timeout_err), 0);
        n = 0;
        while (bus.mem_req && n < 20) begin n++; step(); end
        check("wd_busy_cycles", 32'(n), 8);
        check("wd_d_ready", 32'(bus.d_ready), 1);
        check("wd_err_set", 32'(bus.timeout_err), 1);
        check("wd_d_rdata", bus.d_rdata, prev_d);
        bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        bus.mem_ready = 0; bus.d_req = 0;
        check("wd_late_ready_ign", bus.d_rdata, prev_d);
        check("wd_no_second_pulse", 32'(bus.d_ready), 0);
        check("wd_mem_req_off", 32'(bus.mem_req), 0);
        run_vec(tbl[3]);
        check("wd_err_sticky", 32'(bus.timeout_err), 1);

        // Reset in the middle of a load
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
        step();
        check("rstmid_busy", 32'(bus.mem_req), 1);
        step();
        reset = 1; step(); reset = 0; bus.d_req = 0;
        check("rstmid_mem_req", 32'(bus.mem_req), 0);
        check("rstmid_d_ready", 32'(bus.d_ready), 0);
        check("rstmid_d_rdata", bus.d_rdata, 0);
        check("rstmid_err_clr", 32'(bus.timeout_err), 0);
        bus.mem_ready = 1; bus.mem_rdata = 32'h55; step(); bus.mem_ready = 0;
        check("rstmid_late_ready", 32'(bus.d_ready), 0);
        check("rstmid_late_rdata", bus.d_rdata, 0);
        check("rstmid_idle", 32'(bus.mem_req), 0);
        run_vec(tbl[0]);
        run_vec(tbl[2]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    // Global bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", nerr, nchk);
        $fatal(1);
    end

endmodule
